// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 strip driver.
//   state_t  - frame FSM states (IDLE, LOAD, SHIFT, LATCH)
//   phase_t  - wire phase codes inside one bit cell (PH_HIGH, PH_DATA, PH_LOW)
//   BPP_RGB / BPP_RGBW - the two legal bits-per-pixel values
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      PH_HIGH = 2'd0,
      PH_DATA = 2'd1,
      PH_LOW  = 2'd2
   } phase_t;

   localparam int unsigned BPP_RGB  = 24;
   localparam int unsigned BPP_RGBW = 32;

endpackage

// File: rtl/ws2812_phase_timer.sv
// ws2812_phase_timer: CLK_DIV prescaler that marks the last clk cycle of each
// wire phase.
//   clk   - phase-rate clock
//   rst_n - asynchronous active-low reset
//   en    - count while high; held at zero while low
//   clr   - synchronous restart so the next cycle is the first of a phase
//   tick  - high on the last cycle of the current phase
module ws2812_phase_timer #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // tick depends only on the register so clr (derived from tick) cannot loop
   assign tick = en && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || !en || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ws2812_strip_driver.sv
// ws2812_strip_driver: streams NUM_LEDS pixels of BPP bits to a WS2812 strip.
// Each bit is three phases of CLK_DIV clocks: high, data, low. A frame ends
// with LATCH_PHASES low phases.
//   clk, rst_n        - clock and asynchronous active-low reset
//   start             - frame request (ignored while busy)
//   pix_valid/pix_data/pix_ready - pixel handshake, MSB-first word
//   dout              - registered serial line
//   busy              - state is not IDLE
//   frame_done        - pulse on the last LATCH cycle of a complete frame
//   underrun          - pulse when the frame is aborted for lack of a pixel
// Build option: define WS2812_GRB_EN to send the captured word as G,R,B[,W].
module ws2812_strip_driver
   import ws2812_pkg::*;
#(
   parameter int unsigned NUM_LEDS     = 8,
   parameter int unsigned BPP          = 24,
   parameter int unsigned CLK_DIV      = 1,
   parameter int unsigned LATCH_PHASES = 24
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           pix_valid,
   input  logic [BPP-1:0] pix_data,
   output logic           pix_ready,
   output logic           dout,
   output logic           busy,
   output logic           frame_done,
   output logic           underrun
);

   localparam int unsigned LATCH_CYC = LATCH_PHASES * CLK_DIV;
   localparam int unsigned BW        = $clog2(BPP);
   localparam int unsigned PW        = $clog2(NUM_LEDS + 1);
   localparam int unsigned LW        = $clog2(LATCH_CYC + 1);

   state_t          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [LW-1:0]   latch_q, latch_d;
   logic [BPP-1:0]  shreg_q, shreg_d;
   logic            dout_q, dout_d;
   logic            underrun_q, underrun_d;
   logic            abort_q, abort_d;
   logic            tick;
   logic [BPP-1:0]  pix_word;

`ifdef WS2812_GRB_EN
   assign pix_word = {pix_data[BPP-9 -: 8], pix_data[BPP-1 -: 8], pix_data[BPP-17:0]};
`else
   assign pix_word = pix_data;
`endif

   // Timer restarts on every state change so LOAD timeout and the first
   // SHIFT phase both begin from a fresh count.
   ws2812_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    ((state_q == LOAD) || (state_q == SHIFT)),
      .clr   (state_d != state_q),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      pix_cnt_d  = pix_cnt_q;
      latch_d    = latch_q;
      shreg_d    = shreg_q;
      abort_d    = abort_q;
      underrun_d = 1'b0;
      pix_ready  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               pix_cnt_d = '0;
               abort_d   = 1'b0;
            end
         end
         LOAD: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               shreg_d = pix_word;
               bit_d   = BW'(BPP - 1);
               phase_d = PH_HIGH;
               state_d = SHIFT;
            end else if (tick) begin
               underrun_d = 1'b1;
               abort_d    = 1'b1;
               latch_d    = '0;
               state_d    = LATCH;
            end
         end
         SHIFT: begin
            if (tick) begin
               unique case (phase_q)
                  PH_HIGH: phase_d = PH_DATA;
                  PH_DATA: phase_d = PH_LOW;
                  default: begin
                     phase_d = PH_HIGH;
                     shreg_d = {shreg_q[BPP-2:0], 1'b0};
                     if (bit_q == '0) begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                        if (pix_cnt_q == PW'(NUM_LEDS - 1)) begin
                           latch_d = '0;
                           state_d = LATCH;
                        end else begin
                           state_d = LOAD;
                        end
                     end else begin
                        bit_d = bit_q - BW'(1);
                     end
                  end
               endcase
            end
         end
         LATCH: begin
            if (latch_q == LW'(LATCH_CYC - 1)) begin
               latch_d = '0;
               state_d = IDLE;
            end else begin
               latch_d = latch_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // dout is registered, so it is derived from the next-cycle state/phase
      dout_d = (state_d == SHIFT) &&
               ((phase_d == PH_HIGH) || ((phase_d == PH_DATA) && shreg_d[BPP-1]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phase_q    <= PH_HIGH;
         bit_q      <= '0;
         pix_cnt_q  <= '0;
         latch_q    <= '0;
         shreg_q    <= '0;
         dout_q     <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         pix_cnt_q  <= pix_cnt_d;
         latch_q    <= latch_d;
         shreg_q    <= shreg_d;
         dout_q     <= dout_d;
         underrun_q <= underrun_d;
         abort_q    <= abort_d;
      end
   end

   assign dout       = dout_q;
   assign busy       = (state_q != IDLE);
   assign underrun   = underrun_q;
   assign frame_done = (state_q == LATCH) && (latch_q == LW'(LATCH_CYC - 1)) && !abort_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
module tb_ws2812_strip_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, pix_valid_a, pix_ready_a, dout_a, busy_a, frame_done_a, underrun_a;
   logic [23:0] pix_data_a;
   logic        start_b, pix_valid_b, pix_ready_b, dout_b, busy_b, frame_done_b, underrun_b;
   logic [31:0] pix_data_b;

   int n_cmp = 0;
   int n_err = 0;

   bit rec_dout [512];
   bit rec_busy [512];
   bit rec_fd   [512];
   bit rec_ur   [512];
   bit rec_rdy  [512];
   int rec_n;
   bit rec_to;

   ws2812_strip_driver #(
      .NUM_LEDS     (2),
      .BPP          (24),
      .CLK_DIV      (2),
      .LATCH_PHASES (4)
   ) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_a),
      .pix_valid  (pix_valid_a),
      .pix_data   (pix_data_a),
      .pix_ready  (pix_ready_a),
      .dout       (dout_a),
      .busy       (busy_a),
      .frame_done (frame_done_a),
      .underrun   (underrun_a)
   );

   ws2812_strip_driver #(
      .NUM_LEDS     (1),
      .BPP          (32),
      .CLK_DIV      (1),
      .LATCH_PHASES (4)
   ) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_b),
      .pix_valid  (pix_valid_b),
      .pix_data   (pix_data_b),
      .pix_ready  (pix_ready_b),
      .dout       (dout_b),
      .busy       (busy_b),
      .frame_done (frame_done_b),
      .underrun   (underrun_b)
   );

   function automatic logic [23:0] wire24(input logic [23:0] p);
`ifdef WS2812_GRB_EN
      return {p[15:8], p[23:16], p[7:0]};
`else
      return p;
`endif
   endfunction

   function automatic logic [31:0] wire32(input logic [31:0] p);
`ifdef WS2812_GRB_EN
      return {p[23:16], p[31:24], p[15:0]};
`else
      return p;
`endif
   endfunction

   // Expected dout for DUT A (CLK_DIV=2): pixel 0 cells start at cycle 1,
   // pixel 1 cells at cycle 146 (one LOAD cycle in between), 6 clk per bit.
   function automatic bit exp_dout_a(input int c, input logic [23:0] w0,
                                     input logic [23:0] w1, input int npix);
      int off;
      logic [23:0] w;
      if (c >= 1 && c <= 144) begin
         off = c - 1;
         w   = w0;
      end else if (npix > 1 && c >= 146 && c <= 289) begin
         off = c - 146;
         w   = w1;
      end else begin
         return 1'b0;
      end
      case (off % 6)
         0, 1:    return 1'b1;
         2, 3:    return w[23 - off / 6];
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_frame_a(input logic [23:0] p0, input logic [23:0] p1,
                              input int give_n, input int start_at);
      int idx;
      idx    = 0;
      rec_n  = 0;
      rec_to = 1'b1;
      start_a     = 1'b1;
      pix_valid_a = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int c = 0; c < 500; c++) begin
         rec_dout[c] = dout_a;
         rec_busy[c] = busy_a;
         rec_fd[c]   = frame_done_a;
         rec_ur[c]   = underrun_a;
         rec_rdy[c]  = pix_ready_a;
         rec_n       = c + 1;
         if (!busy_a) begin
            rec_to = 1'b0;
            break;
         end
         start_a     = (c == start_at);
         pix_data_a  = (idx == 0) ? p0 : p1;
         pix_valid_a = (idx < give_n);
         if (pix_ready_a && pix_valid_a) idx++;
         @(posedge clk); #1;
      end
      start_a     = 1'b0;
      pix_valid_a = 1'b0;
   endtask

   task automatic check_wave_a(input string name, input logic [23:0] w0,
                               input logic [23:0] w1, input int npix);
      int errs;
      int first;
      errs  = 0;
      first = -1;
      for (int c = 0; c < rec_n; c++) begin
         if (rec_dout[c] !== exp_dout_a(c, w0, w1, npix)) begin
            errs++;
            if (first < 0) first = c;
         end
      end
      n_cmp++;
      if (errs != 0) begin
         n_err++;
         $display("FAIL %s: %0d dout cycles differ (first at cycle %0d), required 0", name,
                  errs, first);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      int waited;
      bit seen_ur;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({dout_a, busy_a, pix_ready_a, frame_done_a, underrun_a} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs_a: got %b, required 00000",
                  {dout_a, busy_a, pix_ready_a, frame_done_a, underrun_a});
      end
      n_cmp++;
      if ({dout_b, busy_b, pix_ready_b, frame_done_b, underrun_b} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs_b: got %b, required 00000",
                  {dout_b, busy_b, pix_ready_b, frame_done_b, underrun_b});
      end
      // start presented across the first edge after release must be taken
      @(negedge clk);
      rst_n   = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      n_cmp++;
      if ({busy_a, pix_ready_a} !== 2'b11) begin
         n_err++;
         $display("FAIL first_start: busy/ready got %b, required 11", {busy_a, pix_ready_a});
      end
      // no pixel offered: frame aborts and returns to idle
      waited  = 0;
      seen_ur = 1'b0;
      while (busy_a && waited < 40) begin
         if (underrun_a) seen_ur = 1'b1;
         @(posedge clk); #1;
         waited++;
      end
      check_int("first_start_idle_in_time", int'(busy_a), 0);
      check_int("first_start_underrun", int'(seen_ur), 1);
   endtask

   task automatic test_basic_frame();
      int fd_n, fd_i, ur_n, rdy_n, busy_n;
      run_frame_a(24'hFF0000, 24'h00000F, 2, -1);
      check_int("basic_timeout", int'(rec_to), 0);
      check_int("basic_length", rec_n, 299);
      check_wave_a("basic_wave", wire24(24'hFF0000), wire24(24'h00000F), 2);
      fd_n = 0; fd_i = -1; ur_n = 0; rdy_n = 0; busy_n = 0;
      for (int c = 0; c < rec_n; c++) begin
         if (rec_fd[c]) begin
            fd_n++;
            fd_i = c;
         end
         if (rec_ur[c]) ur_n++;
         if (rec_rdy[c] && (c == 0 || c == 145)) rdy_n++;
         else if (rec_rdy[c]) rdy_n += 100;
         if (rec_busy[c]) busy_n++;
      end
      check_int("basic_frame_done_count", fd_n, 1);
      check_int("basic_frame_done_cycle", fd_i, 297);
      check_int("basic_underrun_count", ur_n, 0);
      check_int("basic_ready_cycles", rdy_n, 2);
      check_int("basic_busy_cycles", busy_n, 298);
   endtask

   task automatic test_underrun();
      int fd_n, ur_n, ur_i;
      run_frame_a(24'hFF0000, 24'h00000F, 1, -1);
      check_int("underrun_length", rec_n, 156);
      check_wave_a("underrun_wave", wire24(24'hFF0000), 24'h0, 1);
      fd_n = 0; ur_n = 0; ur_i = -1;
      for (int c = 0; c < rec_n; c++) begin
         if (rec_fd[c]) fd_n++;
         if (rec_ur[c]) begin
            ur_n++;
            ur_i = c;
         end
      end
      check_int("underrun_pulse_count", ur_n, 1);
      check_int("underrun_pulse_cycle", ur_i, 147);
      check_int("underrun_no_frame_done", fd_n, 0);
   endtask

   task automatic test_start_while_busy();
      run_frame_a(24'h00FF00, 24'hA5A5A5, 2, 50);
      check_int("busy_start_length", rec_n, 299);
      check_wave_a("busy_start_wave", wire24(24'h00FF00), wire24(24'hA5A5A5), 2);
      repeat (3) @(posedge clk);
      #1;
      check_int("busy_start_stays_idle", int'(busy_a), 0);
   endtask

   task automatic test_mid_reset();
      pix_data_a  = 24'hFFFF00;
      pix_valid_a = 1'b1;
      start_a     = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (33) @(posedge clk);
      #1;
      // cycle 33 is the data phase of bit 5, which is a one
      check_int("mid_reset_pre_dout", int'(dout_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({dout_a, busy_a, pix_ready_a, frame_done_a, underrun_a} !== 5'b0) begin
         n_err++;
         $display("FAIL mid_reset_async: got %b, required 00000",
                  {dout_a, busy_a, pix_ready_a, frame_done_a, underrun_a});
      end
      pix_valid_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame_a(24'h123456, 24'h89ABCD, 2, -1);
      check_int("mid_reset_refr_length", rec_n, 299);
      check_wave_a("mid_reset_refr_wave", wire24(24'h123456), wire24(24'h89ABCD), 2);
   endtask

   task automatic test_grb_order();
      logic [23:0] got;
      logic [23:0] exp_w;
`ifdef WS2812_GRB_EN
      exp_w = 24'h221133;
`else
      exp_w = 24'h112233;
`endif
      run_frame_a(24'h112233, 24'h000000, 2, -1);
      got = '0;
      for (int k = 0; k < 24; k++) got[23 - k] = rec_dout[3 + 6 * k];
      n_cmp++;
      if (got !== exp_w) begin
         n_err++;
         $display("FAIL grb_order: wire word got %h, required %h", got, exp_w);
      end
   endtask

   task automatic test_edge_params();
      logic [31:0] got, exp_w;
      int shape_err, fd_n, fd_i;
      exp_w       = wire32(32'h80000001);
      pix_data_b  = 32'h80000001;
      pix_valid_b = 1'b1;
      start_b     = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      rec_n   = 0;
      rec_to  = 1'b1;
      for (int c = 0; c < 300; c++) begin
         rec_dout[c] = dout_b;
         rec_fd[c]   = frame_done_b;
         rec_n       = c + 1;
         if (!busy_b) begin
            rec_to = 1'b0;
            break;
         end
         pix_valid_b = (c == 0);
         @(posedge clk); #1;
      end
      pix_valid_b = 1'b0;
      check_int("edge_timeout", int'(rec_to), 0);
      check_int("edge_length", rec_n, 102);
      got = '0;
      shape_err = 0;
      for (int k = 0; k < 32; k++) begin
         got[31 - k] = rec_dout[2 + 3 * k];
         if (rec_dout[1 + 3 * k] !== 1'b1) shape_err++;
         if (rec_dout[3 + 3 * k] !== 1'b0) shape_err++;
      end
      if (rec_dout[0] !== 1'b0) shape_err++;
      for (int c = 97; c < 102; c++) if (rec_dout[c] !== 1'b0) shape_err++;
      n_cmp++;
      if (got !== exp_w) begin
         n_err++;
         $display("FAIL edge_word: wire word got %h, required %h", got, exp_w);
      end
      check_int("edge_shape_errors", shape_err, 0);
      fd_n = 0;
      fd_i = -1;
      for (int c = 0; c < rec_n; c++) begin
         if (rec_fd[c]) begin
            fd_n++;
            fd_i = c;
         end
      end
      check_int("edge_frame_done_count", fd_n, 1);
      check_int("edge_frame_done_cycle", fd_i, 100);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_a     = 1'b0;
      pix_valid_a = 1'b0;
      pix_data_a  = '0;
      start_b     = 1'b0;
      pix_valid_b = 1'b0;
      pix_data_b  = '0;
      test_reset();
      test_basic_frame();
      test_underrun();
      test_start_while_busy();
      test_mid_reset();
      test_grb_order();
      test_edge_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ws2812_strip_driver.md
WS2812_STRIP_DRIVER -- requirements
Module: ws2812_strip_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: pixels per frame, range 1..1024.
REQ-002 SHALL have parameter BPP, default 24: bits per pixel, legal values 24 (RGB) and 32 (RGBW).
REQ-003 SHALL have parameter CLK_DIV, default 1: clk cycles per wire phase, range 1..255.
REQ-004 SHALL have parameter LATCH_PHASES, default 24: low phases forming the latch gap, range 1..1023.
REQ-005 SHALL have port clk, input, 1: phase-rate clock; one clock domain only.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port start, input, 1: frame request pulse.
REQ-008 SHALL have port pix_valid, input, 1: pix_data holds a valid pixel.
REQ-009 SHALL have port pix_data, input, BPP: pixel word {r,g,b[,w]}, MSB first.
REQ-010 SHALL have port pix_ready, output, 1: driver accepts pix_data this cycle.
REQ-011 SHALL have port dout, output, 1: registered serial line to the strip.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at frame end.
REQ-014 SHALL have port underrun, output, 1: one-cycle pulse when a frame is aborted.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH.
REQ-016 IDLE: start=1 -> LOAD next cycle; pixel count cleared; dout=0.
REQ-017 LOAD: pix_ready=1; pix_valid=1 -> capture pix_data, bit index=BPP-1, go to SHIFT next cycle.
REQ-018 LOAD: no pix_valid within CLK_DIV cycles -> underrun pulse, go to LATCH; remaining pixels are not sent.
REQ-019 SHIFT: each bit SHALL take three phases of CLK_DIV cycles each: dout=1, dout=current bit, dout=0.
REQ-020 dout SHALL rise on the first cycle after capture.
REQ-021 After the third phase of bit 0: if NUM_LEDS pixels are done -> LATCH, else -> LOAD.
REQ-022 LATCH: dout=0 for LATCH_PHASES*CLK_DIV cycles, then IDLE; frame_done=1 on the last LATCH cycle, except after an underrun.
REQ-023 start SHALL be ignored whenever busy=1.
REQ-024 pix_ready SHALL be 0 outside LOAD.
REQ-025 Counter widths: phase $clog2(CLK_DIV+1), bit $clog2(BPP), pixel $clog2(NUM_LEDS+1), latch $clog2(LATCH_PHASES*CLK_DIV+1); no counter SHALL wrap inside a frame.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, with dout, pix_ready, busy, frame_done and underrun all 0, and the shift register and all counters cleared, including mid-frame.
REQ-027 The first start SHALL be honoured on the first clk edge after rst_n deasserts.

Configuration
REQ-028 Macro WS2812_GRB_EN defined: the captured word SHALL be reordered on the wire as G,R,B[,W], each byte MSB first.
REQ-029 WS2812_GRB_EN undefined: bits SHALL be sent exactly as pix_data order, MSB first.

Structure
REQ-030 Package ws2812_pkg SHALL hold the FSM state enum typedef, the phase codes (PH_HIGH, PH_DATA, PH_LOW) and the legal-BPP constants.
REQ-031 Sub-module ws2812_phase_timer (CLK_DIV prescaler, phase tick output) SHALL be instantiated once; everything else stays in the top module.

Verification
All scenarios use NUM_LEDS=2, BPP=24, CLK_DIV=2, LATCH_PHASES=4 unless stated.
REQ-032 Basic frame: start, then pixels 0xFF0000 and 0x00000F with valid held -> 48 bits, each 2 clk high, 2 clk data, 2 clk low; frame_done exactly 8 clk after the last low phase; busy falls the next cycle.
REQ-033 Underrun: pix_valid withheld after pixel 0 -> underrun pulse 2 clk after LOAD entry; LATCH 8 clk; no frame_done.
REQ-034 Start while busy: start pulsed mid-SHIFT -> ignored; exactly 48 bits sent.
REQ-035 Mid-frame reset: rst_n low during bit 5 -> dout=0, busy=0 asynchronously; a new start after release sends a full frame.
REQ-036 WS2812_GRB_EN defined, pixel 0x112233 -> wire bits 0x221133; macro undefined -> 0x112233.
REQ-037 Edge parameters, NUM_LEDS=1, CLK_DIV=1, BPP=32, pixel 0x80000001 -> 96 clk of SHIFT; first and last data phases high.
